ibf_cfg_sequencer: RTL and testbench
====================================

// Module: ibf_cfg_sequencer
// PURPOSE
//  Loads, arms and commits switch configuration for a chain of STAGE_NUM ibf/bf 2x2 stages.
//  Host streams one config word per stage into a shadow bank over valid/ready.
//  On swap_req, shadow is copied to the active bank driving each stage's config_data.
//  With IS_PIPED=1 the copy is skewed one stage per cycle, so each in-flight data word sees one coherent config.
// PARAMETERS
//  DATA_WIDTH  32  network width; each stage config is DATA_WIDTH/2 bits (HALF_W)
//  STAGE_NUM   5   number of stages driven; must be >=2 (default = log2(DATA_WIDTH))
//  IS_PIPED    1   1: stages are registered, skewed commit; 0: combinational, single-cycle commit
//  EPOCH_W     8   width of the commit counter
// PORTS
//  clk         in   1                  clock, all logic on rising edge
//  rst_n       in   1                  asynchronous active-low reset
//  cfg_valid   in   1                  host config beat valid
//  cfg_ready   out  1                  block accepts a beat (beat taken when valid&ready)
//  cfg_data    in   HALF_W             config word for stage at current beat index
//  cfg_last    in   1                  marks final beat of a config set
//  swap_req    in   1                  commit request; honoured only in ARMED
//  stage_cfg   out  STAGE_NUM*HALF_W   active config; stage s at [s*HALF_W +: HALF_W]
//  busy        out  1                  state != IDLE
//  armed       out  1                  state == ARMED
//  swap_done   out  1                  1-cycle pulse, commit complete
//  cfg_err     out  1                  1-cycle pulse, malformed config set discarded
//  cfg_epoch   out  EPOCH_W            count of completed commits, wraps modulo 2^EPOCH_W
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; shadow and active banks = 0 (all switches straight)
//   cfg_ready=1; busy, armed, swap_done and cfg_err = 0; cfg_epoch=0; beat_cnt=0.
//  FSM states: IDLE, LOAD, ARMED, SWAP. All outputs are registered or decoded from state only.
//  IDLE:  cfg_ready=1.
//   Accepted beat is written to shadow[0], beat_cnt<=1, next state LOAD.
//   If that beat has cfg_last=1: cfg_err pulse and stay IDLE. The shadow write still occurs but is never committed.
//  LOAD:  cfg_ready=1. Accepted beat is written to shadow[beat_cnt], beat_cnt++.
//   cfg_last=1 with beat_cnt==STAGE_NUM-1 -> ARMED.
//   cfg_last=1 with beat_cnt<STAGE_NUM-1 -> cfg_err pulse, IDLE.
//   cfg_last=0 with beat_cnt==STAGE_NUM-1 -> cfg_err pulse, IDLE.
//   cfg_valid=0 holds state indefinitely; there is no timeout.
//  ARMED: cfg_ready=0. swap_req=1 sampled at edge N -> SWAP, sk<=0.
//  SWAP:  cfg_ready=0.
//   IS_PIPED=1: active[sk]<=shadow[sk] at edges N+1+sk, for sk=0..STAGE_NUM-1.
//   IS_PIPED=0: all active stages load at edge N+1.
//   On the final copy edge: swap_done<=1 for one cycle, cfg_epoch++, state<=IDLE.
//   cfg_ready=1 in the following cycle.
//  swap_req in IDLE, LOAD or SWAP is ignored and not queued. cfg_valid while cfg_ready=0 is not consumed.
//  Active bank changes only in SWAP; stage_cfg is stable in every other state.
//  cfg_err and swap_done are never asserted in the same cycle.
//  Reset mid-LOAD or mid-SWAP: both banks clear immediately, including stages already committed. No partial state survives.
// STRUCTURE
//  Shared package ibf_ctrl_pkg holds:
//   - FSM state encoding (2-bit enum)
//   - HALF_W and STAGE_IDX_W = clog2(STAGE_NUM) localparams
//   - clog2 function, shared with the ibf/bf stage wrappers
//  Sub-module ibf_cfg_bank: shadow and active arrays with per-stage shadow write enable,
//   per-stage copy enable, and flattened stage_cfg output.
//  The FSM, beat counter, skew counter and epoch counter stay in this module.
// TESTING  (DATA_WIDTH=8, STAGE_NUM=3, HALF_W=4 unless noted)
//  1 Reset: stage_cfg=12'h000, cfg_ready=1, busy=0, cfg_epoch=0; assert rst_n low mid-cycle -> outputs clear with no clock edge.
//  2 Beats A,5,F (last on F), then swap_req at edge N, IS_PIPED=1:
//    stage0=A at N+1, stage1=5 at N+2, stage2=F at N+3; swap_done pulses with the stage2 update; epoch=1; stage_cfg=12'hF5A.
//  3 Same stimulus with IS_PIPED=0 -> stage_cfg=12'hF5A at N+1, swap_done at N+1.
//  4 cfg_last on 2nd beat, or 3rd beat without cfg_last -> cfg_err 1-cycle pulse, IDLE, stage_cfg unchanged;
//    a following swap_req causes no update.
//  5 cfg_valid held high through ARMED/SWAP -> cfg_ready=0 and no shadow write;
//    swap_req pulsed in IDLE and LOAD -> no change; 256 commits with EPOCH_W=8 -> epoch wraps to 0.
//  6 Reset asserted the cycle after stage0 updates in SWAP -> stage_cfg=0, state IDLE, epoch unchanged from its reset value 0.

Source files
------------

// File: rtl/ibf_ctrl_pkg.sv
// Shared control definitions for the ibf/bf stage chain: FSM encoding,
// default geometry and the clog2 helper used by the stage wrappers.
package ibf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_SWAP  = 2'd3
  } cfg_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width for a stage counter; never narrower than one bit.
  function automatic int unsigned stage_idx_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned HALF_W         = DATA_WIDTH_DEF / 2;
  localparam int unsigned STAGE_NUM_DEF  = clog2(DATA_WIDTH_DEF);
  localparam int unsigned STAGE_IDX_W    = stage_idx_w(STAGE_NUM_DEF);

endpackage

// File: rtl/ibf_cfg_bank.sv
// Shadow and active configuration registers for the stage chain, with
// per-stage shadow write and per-stage shadow->active copy enables.
module ibf_cfg_bank
  import ibf_ctrl_pkg::*;
#(
  parameter int unsigned CFG_W     = HALF_W,
  parameter int unsigned STAGE_NUM = STAGE_NUM_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [STAGE_NUM-1:0]         shadow_we,
  input  logic [CFG_W-1:0]             shadow_wdata,
  input  logic [STAGE_NUM-1:0]         copy_en,
  output logic [STAGE_NUM*CFG_W-1:0]   stage_cfg
);

  logic [CFG_W-1:0] shadow [STAGE_NUM];
  logic [CFG_W-1:0] active [STAGE_NUM];

  // Reset clears both banks at once, including stages already committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (shadow_we[s]) shadow[s] <= shadow_wdata;
        if (copy_en[s])   active[s] <= shadow[s];
      end
    end
  end

  for (genvar g = 0; g < STAGE_NUM; g++) begin : g_flat
    assign stage_cfg[g*CFG_W +: CFG_W] = active[g];
  end

endmodule

// File: rtl/ibf_cfg_sequencer.sv
// Loads a per-stage config set into the shadow bank, arms it, and commits it
// to the active bank on swap_req (skewed one stage per cycle when piped).
module ibf_cfg_sequencer
  import ibf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned STAGE_NUM  = STAGE_NUM_DEF,
  parameter bit          IS_PIPED   = 1'b1,
  parameter int unsigned EPOCH_W    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [DATA_WIDTH/2-1:0]             cfg_data,
  input  logic                                cfg_last,
  input  logic                                swap_req,
  output logic [STAGE_NUM*(DATA_WIDTH/2)-1:0] stage_cfg,
  output logic                                busy,
  output logic                                armed,
  output logic                                swap_done,
  output logic                                cfg_err,
  output logic [EPOCH_W-1:0]                  cfg_epoch
);

  localparam int unsigned      CFG_W    = DATA_WIDTH / 2;
  localparam int unsigned      IDX_W    = stage_idx_w(STAGE_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM - 1);

  cfg_state_t           state;
  logic [IDX_W-1:0]     beat_cnt;
  logic [IDX_W-1:0]     sk;
  logic                 beat_acc;
  logic [IDX_W-1:0]     wr_idx;
  logic                 final_copy;
  logic [STAGE_NUM-1:0] shadow_we;
  logic [STAGE_NUM-1:0] copy_en;

  // cfg_ready is only high in IDLE/LOAD, so a handshake implies a load state.
  assign beat_acc   = cfg_valid & cfg_ready;
  assign wr_idx     = (state == ST_IDLE) ? '0 : beat_cnt;
  assign final_copy = (state == ST_SWAP) && (!IS_PIPED || (sk == LAST_IDX));

  always_comb begin
    shadow_we = '0;
    copy_en   = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      shadow_we[s] = beat_acc && (wr_idx == IDX_W'(s));
      copy_en[s]   = (state == ST_SWAP) && (!IS_PIPED || (sk == IDX_W'(s)));
    end
  end

  // Control FSM; status outputs are updated alongside each state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      sk        <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      armed     <= 1'b0;
      swap_done <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_epoch <= '0;
    end else begin
      swap_done <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (beat_acc) begin
            if (cfg_last) begin
              cfg_err <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              beat_cnt <= IDX_W'(1);
              busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (cfg_last && (beat_cnt == LAST_IDX)) begin
              state     <= ST_ARMED;
              beat_cnt  <= '0;
              cfg_ready <= 1'b0;
              armed     <= 1'b1;
            end else if (cfg_last || (beat_cnt == LAST_IDX)) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
              busy     <= 1'b0;
              cfg_err  <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (swap_req) begin
            state <= ST_SWAP;
            sk    <= '0;
            armed <= 1'b0;
          end
        end
        ST_SWAP: begin
          sk <= sk + 1'b1;
          if (final_copy) begin
            state     <= ST_IDLE;
            sk        <= '0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            swap_done <= 1'b1;
            cfg_epoch <= cfg_epoch + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ibf_cfg_bank #(
    .CFG_W     (CFG_W),
    .STAGE_NUM (STAGE_NUM)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .shadow_we    (shadow_we),
    .shadow_wdata (cfg_data),
    .copy_en      (copy_en),
    .stage_cfg    (stage_cfg)
  );

endmodule

// File: tb/tb_ibf_cfg_sequencer.sv
// Drives a piped and a non-piped sequencer with identical random config
// traffic and checks both against a transaction-level model.
module tb_ibf_cfg_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned SN = 3;
  localparam int unsigned HW = DW / 2;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = SN * HW;

  typedef struct {
    bit            is_done;
    logic [CW-1:0] cfg;
    logic [EW-1:0] epoch;
  } ev_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_last  = 1'b0;
  logic          swap_req  = 1'b0;
  logic [HW-1:0] cfg_data  = '0;

  logic          rdy   [2];
  logic          busy  [2];
  logic          armed [2];
  logic          sdone [2];
  logic          cerr  [2];
  logic [CW-1:0] stg   [2];
  logic [EW-1:0] epo   [2];

  int n_cmp   = 0;
  int n_bad   = 0;
  int commits = 0;

  logic [HW-1:0] m_active [SN];
  logic [HW-1:0] m_shadow [SN];
  int            m_epoch = 0;
  ev_t           q_p [$];
  ev_t           q_c [$];
  ev_t           mon_ev;

  always #5 clk = ~clk;

  ibf_cfg_sequencer #(.DATA_WIDTH(DW), .STAGE_NUM(SN), .IS_PIPED(1'b1), .EPOCH_W(EW)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .swap_req(swap_req), .stage_cfg(stg[0]), .busy(busy[0]),
    .armed(armed[0]), .swap_done(sdone[0]), .cfg_err(cerr[0]), .cfg_epoch(epo[0]));

  ibf_cfg_sequencer #(.DATA_WIDTH(DW), .STAGE_NUM(SN), .IS_PIPED(1'b0), .EPOCH_W(EW)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .swap_req(swap_req), .stage_cfg(stg[1]), .busy(busy[1]),
    .armed(armed[1]), .swap_done(sdone[1]), .cfg_err(cerr[1]), .cfg_epoch(epo[1]));

  task automatic chk_d(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Expected flattened config after k stages have taken the shadow value.
  function automatic logic [CW-1:0] pack_mix(input int k);
    logic [CW-1:0] v;
    v = '0;
    for (int s = 0; s < int'(SN); s++)
      v[s*HW +: HW] = (s < k) ? m_shadow[s] : m_active[s];
    return v;
  endfunction

  task automatic push_ev(input bit is_done, input logic [CW-1:0] cfg, input logic [EW-1:0] ep);
    ev_t e;
    e.is_done = is_done;
    e.cfg     = cfg;
    e.epoch   = ep;
    q_p.push_back(e);
    q_c.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < int'(SN); s++) begin
      m_active[s] = '0;
      m_shadow[s] = '0;
    end
    m_epoch = 0;
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk_d("rst_stage_cfg", d, 64'(stg[d]), 64'd0);
      chk_d("rst_cfg_ready", d, 64'(rdy[d]), 64'd1);
      chk_d("rst_busy", d, 64'(busy[d]), 64'd0);
      chk_d("rst_armed", d, 64'(armed[d]), 64'd0);
      chk_d("rst_epoch", d, 64'(epo[d]), 64'd0);
      chk_d("rst_swap_done", d, 64'(sdone[d]), 64'd0);
      chk_d("rst_cfg_err", d, 64'(cerr[d]), 64'd0);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk_d("done_err_excl", d, 64'(sdone[d] & cerr[d]), 64'd0);
        if (sdone[d] || cerr[d]) begin
          if ((d == 0 && q_p.size() == 0) || (d == 1 && q_c.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event[dut%0d] @%0t: done=%0b err=%0b, none expected",
                     d, $time, sdone[d], cerr[d]);
          end else begin
            if (d == 0) mon_ev = q_p.pop_front();
            else        mon_ev = q_c.pop_front();
            chk_d("event_kind", d, 64'(sdone[d]), 64'(mon_ev.is_done));
            chk_d("event_cfg", d, 64'(stg[d]), 64'(mon_ev.cfg));
            chk_d("event_epoch", d, 64'(epo[d]), 64'(mon_ev.epoch));
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [HW-1:0] data, input bit last);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      swap_req = 1'($urandom_range(0, 1));
      tick();
    end
    for (int d = 0; d < 2; d++) chk_d("ready_for_beat", d, 64'(rdy[d]), 64'd1);
    cfg_valid = 1'b1;
    cfg_data  = data;
    cfg_last  = last;
    swap_req  = 1'($urandom_range(0, 1));
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    swap_req  = 1'b0;
  endtask

  // kind 0: well-formed set; 1: early cfg_last on beat len; 2: missing cfg_last.
  task automatic do_set(input int kind, input int len);
    logic [HW-1:0] data;
    bit            last;
    for (int i = 0; i < len; i++) begin
      data = HW'($urandom);
      last = (kind != 2) && (i == len - 1);
      if (kind == 0) m_shadow[i] = data;
      if (kind != 0 && i == len - 1) push_ev(1'b0, pack_mix(0), EW'(m_epoch));
      send_beat(data, last);
    end
    if (kind != 0) begin
      for (int d = 0; d < 2; d++) chk_d("err_back_idle", d, 64'(busy[d]), 64'd0);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
        chk_d("err_swap_ignored_cfg", d, 64'(stg[d]), 64'(pack_mix(0)));
        chk_d("err_swap_ignored_busy", d, 64'(busy[d]), 64'd0);
      end
    end
  endtask

  task automatic do_commit();
    int wait_n;
    logic [CW-1:0] new_cfg;
    for (int d = 0; d < 2; d++) begin
      chk_d("armed_flag", d, 64'(armed[d]), 64'd1);
      chk_d("armed_ready", d, 64'(rdy[d]), 64'd0);
      chk_d("armed_busy", d, 64'(busy[d]), 64'd1);
    end
    wait_n = $urandom_range(0, 3);
    for (int i = 0; i < wait_n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = HW'($urandom);
      cfg_last  = 1'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        chk_d("armed_hold_ready", d, 64'(rdy[d]), 64'd0);
        chk_d("armed_hold_cfg", d, 64'(stg[d]), 64'(pack_mix(0)));
      end
    end
    new_cfg = pack_mix(SN);
    push_ev(1'b1, new_cfg, EW'(m_epoch + 1));
    cfg_valid = 1'b1;
    swap_req  = 1'b1;
    tick();
    swap_req = 1'($urandom_range(0, 1));
    for (int k = 1; k <= int'(SN); k++) begin
      tick();
      if (k == 1) begin
        swap_req  = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
      end
      chk_d("swap_stage_cfg", 0, 64'(stg[0]), 64'(pack_mix(k)));
      chk_d("swap_done_time", 0, 64'(sdone[0]), 64'(k == int'(SN)));
      chk_d("swap_ready", 0, 64'(rdy[0]), 64'(k == int'(SN)));
      chk_d("swap_busy", 0, 64'(busy[0]), 64'(k != int'(SN)));
      chk_d("swap_stage_cfg", 1, 64'(stg[1]), 64'(new_cfg));
      chk_d("swap_done_time", 1, 64'(sdone[1]), 64'(k == 1));
      chk_d("swap_ready", 1, 64'(rdy[1]), 64'd1);
    end
    for (int s = 0; s < int'(SN); s++) m_active[s] = m_shadow[s];
    m_epoch = (m_epoch + 1) % (1 << EW);
    commits++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Directed: A,5,F then commit.
    m_shadow[0] = 4'hA;
    m_shadow[1] = 4'h5;
    m_shadow[2] = 4'hF;
    send_beat(4'hA, 1'b0);
    send_beat(4'h5, 1'b0);
    send_beat(4'hF, 1'b1);
    do_commit();
    for (int d = 0; d < 2; d++) begin
      chk_d("directed_cfg", d, 64'(stg[d]), 64'h0F5A);
      chk_d("directed_epoch", d, 64'(epo[d]), 64'd1);
    end

    // Directed malformed sets.
    do_set(1, 1);
    do_set(1, 2);
    do_set(2, SN);

    // Random traffic through an epoch wrap.
    while (commits < 270) begin
      case ($urandom_range(0, 4))
        0:       do_set(1, $urandom_range(1, SN - 1));
        1:       do_set(2, SN);
        default: begin do_set(0, SN); do_commit(); end
      endcase
    end
    for (int d = 0; d < 2; d++) chk_d("epoch_after_wrap", d, 64'(epo[d]), 64'(m_epoch));

    // Asynchronous reset mid-LOAD, asserted between clock edges.
    send_beat(HW'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset the cycle after stage0 commits.
    do_set(0, SN);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    chk_d("partial_swap_cfg", 0, 64'(stg[0]), 64'(pack_mix(1)));
    chk_d("comb_swap_done", 1, 64'(sdone[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_set(0, SN);
      do_commit();
    end

    repeat (3) tick();
    chk_d("events_drained", 0, 64'(q_p.size()), 64'd0);
    chk_d("events_drained", 1, 64'(q_c.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
